// File: rtl/stk_ctx_ctrl.sv
// Multi-context stack controller: ENGS_N LIFO stacks striped across BANKS_N single-port SRAM banks.
// Define STK_CTX_CTRL_SCRUB_EN to zero an engine's whole region on INV (stalls commands meanwhile).
module stk_ctx_ctrl #(
    parameter int ENGS_N  = 4,
    parameter int BANKS_N = 4,
    parameter int LINES_N = 1024,
    parameter int W       = 32,
    localparam int ENG_W  = (ENGS_N > 1) ? $clog2(ENGS_N) : 1,
    localparam int LINE_W = (LINES_N > 1) ? $clog2(LINES_N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_vld,
    output logic                 cmd_rdy,
    input  logic [1:0]           cmd_opcode,
    input  logic [ENG_W-1:0]     cmd_engid,
    input  logic [W-1:0]         cmd_data,
    output logic                 rsp_vld,
    output logic [ENG_W-1:0]     rsp_engid,
    output logic [1:0]           rsp_opcode,
    output logic [W-1:0]         rsp_data,
    output logic                 rsp_err,
    output logic [ENGS_N-1:0]    eng_empty,
    output logic [ENGS_N-1:0]    eng_full,
    output logic [BANKS_N-1:0]   bank_en,
    output logic                 bank_wen,
    output logic [LINE_W-1:0]    bank_addr,
    output logic [W-1:0]         bank_wdata,
    input  logic [BANKS_N*W-1:0] bank_rdata
);
    localparam int DEPTH  = BANKS_N * LINES_N / ENGS_N;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int A_W    = (BANKS_N * LINES_N > 1) ? $clog2(BANKS_N * LINES_N) : 1;
    localparam int BANK_W = $clog2(BANKS_N);
    localparam int BSEL_W = (BANKS_N > 1) ? BANK_W : 1;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_INV  = 2'b11;

`ifdef STK_CTX_CTRL_SCRUB_EN
    localparam int LPE   = LINES_N / ENGS_N;
    localparam int SCR_W = (LPE > 1) ? $clog2(LPE) : 1;
    typedef enum logic {ST_IDLE, ST_SCRUB} state_t;
    logic [SCR_W-1:0] scr_cnt_q, scr_cnt_d;
    logic [ENG_W-1:0] scr_eng_q, scr_eng_d;
`else
    typedef enum logic {ST_IDLE} state_t;
`endif

    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q [ENGS_N];
    logic [CNT_W-1:0] cnt_d [ENGS_N];

    logic               s1_vld_q, s1_vld_d, s1_err_q, s1_err_d, s1_rd_q, s1_rd_d;
    logic [ENG_W-1:0]   s1_eng_q, s1_eng_d;
    logic [1:0]         s1_op_q, s1_op_d;
    logic [BSEL_W-1:0]  s1_bank_q, s1_bank_d;
    logic               rsp_vld_q, rsp_vld_d, rsp_err_q, rsp_err_d, rsp_rd_q, rsp_rd_d;
    logic [ENG_W-1:0]   rsp_eng_q, rsp_eng_d;
    logic [1:0]         rsp_op_q, rsp_op_d;
    logic [BSEL_W-1:0]  rsp_bank_q, rsp_bank_d;
    logic [BANKS_N-1:0] bank_en_q, bank_en_d;
    logic               bank_wen_q, bank_wen_d;
    logic [LINE_W-1:0]  bank_addr_q, bank_addr_d;
    logic [W-1:0]       bank_wdata_q, bank_wdata_d;

    logic               accept, is_full, is_empty;
    logic [CNT_W-1:0]   cur_cnt, slot;
    logic [A_W-1:0]     a_idx;
    logic [BSEL_W-1:0]  bank_sel;
    logic [LINE_W-1:0]  line_sel;

    assign cmd_rdy  = ~rst & (state_q == ST_IDLE);
    assign accept   = cmd_vld & cmd_rdy;
    assign cur_cnt  = cnt_q[cmd_engid];
    assign is_full  = (cur_cnt == CNT_W'(DEPTH));
    assign is_empty = (cur_cnt == '0);
    assign slot     = (cmd_opcode == OP_POP) ? cur_cnt - 1'b1 : cur_cnt;
    // Low address bits pick the bank so consecutive entries stripe across banks.
    assign a_idx    = A_W'(cmd_engid) * A_W'(DEPTH) + A_W'(slot);
    assign bank_sel = (BANKS_N > 1) ? BSEL_W'(a_idx) : '0;
    assign line_sel = LINE_W'(a_idx >> BANK_W);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        s1_vld_d     = 1'b0;
        s1_err_d     = 1'b0;
        s1_rd_d      = 1'b0;
        s1_eng_d     = cmd_engid;
        s1_op_d      = cmd_opcode;
        s1_bank_d    = bank_sel;
        bank_en_d    = '0;
        bank_wen_d   = 1'b0;
        bank_addr_d  = line_sel;
        bank_wdata_d = cmd_data;
        rsp_vld_d    = s1_vld_q;
        rsp_err_d    = s1_err_q;
        rsp_rd_d     = s1_rd_q;
        rsp_eng_d    = s1_eng_q;
        rsp_op_d     = s1_op_q;
        rsp_bank_d   = s1_bank_q;
`ifdef STK_CTX_CTRL_SCRUB_EN
        scr_cnt_d    = scr_cnt_q;
        scr_eng_d    = scr_eng_q;
`endif
        if (accept) begin
            case (cmd_opcode)
                OP_PUSH: begin
                    s1_vld_d = 1'b1;
                    if (is_full) begin
                        s1_err_d = 1'b1;
                    end else begin
                        bank_en_d[bank_sel] = 1'b1;
                        bank_wen_d          = 1'b1;
                        cnt_d[cmd_engid]    = cur_cnt + 1'b1;
                    end
                end
                OP_POP: begin
                    s1_vld_d = 1'b1;
                    if (is_empty) begin
                        s1_err_d = 1'b1;
                    end else begin
                        bank_en_d[bank_sel] = 1'b1;
                        s1_rd_d             = 1'b1;
                        cnt_d[cmd_engid]    = slot;
                    end
                end
                OP_INV: begin
                    cnt_d[cmd_engid] = '0;
`ifdef STK_CTX_CTRL_SCRUB_EN
                    // The response is deferred until the last scrub line is written.
                    state_d      = ST_SCRUB;
                    scr_eng_d    = cmd_engid;
                    scr_cnt_d    = '0;
                    bank_en_d    = '1;
                    bank_wen_d   = 1'b1;
                    bank_addr_d  = LINE_W'(cmd_engid) * LINE_W'(LPE);
                    bank_wdata_d = '0;
`else
                    s1_vld_d = 1'b1;
`endif
                end
                default: ;
            endcase
        end
`ifdef STK_CTX_CTRL_SCRUB_EN
        if (state_q == ST_SCRUB) begin
            if (scr_cnt_q == SCR_W'(LPE - 1)) begin
                state_d   = ST_IDLE;
                rsp_vld_d = 1'b1;
                rsp_err_d = 1'b0;
                rsp_rd_d  = 1'b0;
                rsp_eng_d = scr_eng_q;
                rsp_op_d  = OP_INV;
            end else begin
                scr_cnt_d    = scr_cnt_q + 1'b1;
                bank_en_d    = '1;
                bank_wen_d   = 1'b1;
                bank_addr_d  = LINE_W'(scr_eng_q) * LINE_W'(LPE) + LINE_W'(scr_cnt_d);
                bank_wdata_d = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '{default: '0};
            s1_vld_q     <= 1'b0;
            s1_err_q     <= 1'b0;
            s1_rd_q      <= 1'b0;
            s1_eng_q     <= '0;
            s1_op_q      <= OP_NOP;
            s1_bank_q    <= '0;
            rsp_vld_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rd_q     <= 1'b0;
            rsp_eng_q    <= '0;
            rsp_op_q     <= OP_NOP;
            rsp_bank_q   <= '0;
            bank_en_q    <= '0;
            bank_wen_q   <= 1'b0;
            bank_addr_q  <= '0;
            bank_wdata_q <= '0;
`ifdef STK_CTX_CTRL_SCRUB_EN
            scr_cnt_q    <= '0;
            scr_eng_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            s1_vld_q     <= s1_vld_d;
            s1_err_q     <= s1_err_d;
            s1_rd_q      <= s1_rd_d;
            s1_eng_q     <= s1_eng_d;
            s1_op_q      <= s1_op_d;
            s1_bank_q    <= s1_bank_d;
            rsp_vld_q    <= rsp_vld_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rd_q     <= rsp_rd_d;
            rsp_eng_q    <= rsp_eng_d;
            rsp_op_q     <= rsp_op_d;
            rsp_bank_q   <= rsp_bank_d;
            bank_en_q    <= bank_en_d;
            bank_wen_q   <= bank_wen_d;
            bank_addr_q  <= bank_addr_d;
            bank_wdata_q <= bank_wdata_d;
`ifdef STK_CTX_CTRL_SCRUB_EN
            scr_cnt_q    <= scr_cnt_d;
            scr_eng_q    <= scr_eng_d;
`endif
        end
    end

    generate
        for (genvar gi = 0; gi < ENGS_N; gi++) begin : g_eng_flags
            assign eng_empty[gi] = (cnt_q[gi] == '0);
            assign eng_full[gi]  = (cnt_q[gi] == CNT_W'(DEPTH));
        end
    endgenerate

    assign rsp_vld    = rsp_vld_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_engid  = rsp_eng_q;
    assign rsp_opcode = rsp_op_q;
    // Read data arrives from the SRAM in the response cycle, so it is selected combinationally.
    assign rsp_data   = rsp_rd_q ? bank_rdata[rsp_bank_q*W +: W] : '0;
    assign bank_en    = bank_en_q;
    assign bank_wen   = bank_wen_q;
    assign bank_addr  = bank_addr_q;
    assign bank_wdata = bank_wdata_q;
endmodule

// File: tb/tb_stk_ctx_ctrl.sv
// Directed bench for stk_ctx_ctrl (default parameters) with a behavioural SRAM bank pool.
module tb_stk_ctx_ctrl;
    localparam logic [1:0] OP_NOP = 2'b00, OP_PUSH = 2'b01, OP_POP = 2'b10, OP_INV = 2'b11;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_vld;
    logic         cmd_rdy;
    logic [1:0]   cmd_opcode;
    logic [1:0]   cmd_engid;
    logic [31:0]  cmd_data;
    logic         rsp_vld;
    logic [1:0]   rsp_engid;
    logic [1:0]   rsp_opcode;
    logic [31:0]  rsp_data;
    logic         rsp_err;
    logic [3:0]   eng_empty;
    logic [3:0]   eng_full;
    logic [3:0]   bank_en;
    logic         bank_wen;
    logic [9:0]   bank_addr;
    logic [31:0]  bank_wdata;
    logic [127:0] bank_rdata;

    stk_ctx_ctrl dut (
        .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .cmd_opcode(cmd_opcode), .cmd_engid(cmd_engid), .cmd_data(cmd_data),
        .rsp_vld(rsp_vld), .rsp_engid(rsp_engid), .rsp_opcode(rsp_opcode),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .eng_empty(eng_empty), .eng_full(eng_full),
        .bank_en(bank_en), .bank_wen(bank_wen), .bank_addr(bank_addr),
        .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [4][1024];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bank_en[b]) begin
                if (bank_wen) mem[b][bank_addr] <= bank_wdata;
                else          bank_rdata[b*32 +: 32] <= mem[b][bank_addr];
            end
        end
    end

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  eng;
        logic [31:0] data;
        logic [3:0]  en;
        logic [9:0]  addr;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    int nvec = 0;
    int errs = 0;
    logic [36:0] exp_q [$];
    logic [36:0] mon_e;
    vec_t tbl [22];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [1:0] op, input logic [1:0] eng, input logic [31:0] data,
                                 input logic [3:0] en, input logic [9:0] addr, input logic err,
                                 input logic [31:0] rd);
        vec_t v;
        v.op = op; v.eng = eng; v.data = data; v.en = en; v.addr = addr; v.err = err; v.rd = rd;
        return v;
    endfunction

    // Drives one command, returns on the falling edge after it is accepted (the T+1 bank cycle).
    task automatic send(input string tag, input vec_t v);
        int waitc = 0;
        cmd_vld = 1'b1; cmd_opcode = v.op; cmd_engid = v.eng; cmd_data = v.data;
        while (cmd_rdy !== 1'b1 && waitc < 1000) begin
            @(negedge clk);
            waitc++;
        end
        if (cmd_rdy !== 1'b1) begin
            chk({tag, "_rdy_timeout"}, 64'(cmd_rdy), 64'd1);
            cmd_vld = 1'b0;
            return;
        end
        @(negedge clk);
        if (v.op != OP_NOP) exp_q.push_back({v.eng, v.op, v.err, v.rd});
        $display("cmd %s op=%0d eng=%0d data=%h", tag, v.op, v.eng, v.data);
        if (v.op == OP_INV) return;
        if (v.en == 4'd0)
            chk({tag, "_bank_idle"}, 64'(bank_en), 64'd0);
        else if (v.op == OP_PUSH)
            chk({tag, "_bank_wr"}, 64'({bank_en, bank_wen, bank_addr, bank_wdata}),
                64'({v.en, 1'b1, v.addr, v.data}));
        else
            chk({tag, "_bank_rd"}, 64'({bank_en, bank_wen, bank_addr}), 64'({v.en, 1'b0, v.addr}));
    endtask

    task automatic idle(input int n);
        cmd_vld = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rsp_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_vld), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp", 64'({rsp_engid, rsp_opcode, rsp_err, rsp_data}), 64'(mon_e));
            end
        end
    end

    initial begin
        for (int b = 0; b < 4; b++)
            for (int l = 0; l < 1024; l++) mem[b][l] = 32'd0;
        bank_rdata = '0;
        tbl[0]  = mkv(OP_PUSH, 2'd0, 32'hA5,   4'b0001, 10'd0,   1'b0, 32'h0);
        tbl[1]  = mkv(OP_POP,  2'd0, 32'h0,    4'b0001, 10'd0,   1'b0, 32'hA5);
        tbl[2]  = mkv(OP_POP,  2'd1, 32'h0,    4'b0000, 10'd0,   1'b1, 32'h0);
        tbl[3]  = mkv(OP_PUSH, 2'd0, 32'h11,   4'b0001, 10'd0,   1'b0, 32'h0);
        tbl[4]  = mkv(OP_PUSH, 2'd3, 32'h33,   4'b0001, 10'd768, 1'b0, 32'h0);
        tbl[5]  = mkv(OP_POP,  2'd0, 32'h0,    4'b0001, 10'd0,   1'b0, 32'h11);
        tbl[6]  = mkv(OP_POP,  2'd3, 32'h0,    4'b0001, 10'd768, 1'b0, 32'h33);
        tbl[7]  = mkv(OP_PUSH, 2'd0, 32'h1,    4'b0001, 10'd0,   1'b0, 32'h0);
        tbl[8]  = mkv(OP_PUSH, 2'd0, 32'h2,    4'b0010, 10'd0,   1'b0, 32'h0);
        tbl[9]  = mkv(OP_PUSH, 2'd3, 32'h3,    4'b0001, 10'd768, 1'b0, 32'h0);
        tbl[10] = mkv(OP_POP,  2'd0, 32'h0,    4'b0010, 10'd0,   1'b0, 32'h2);
        tbl[11] = mkv(OP_NOP,  2'd2, 32'h77,   4'b0000, 10'd0,   1'b0, 32'h0);
        tbl[12] = mkv(OP_POP,  2'd0, 32'h0,    4'b0001, 10'd0,   1'b0, 32'h1);
        tbl[13] = mkv(OP_POP,  2'd0, 32'h0,    4'b0000, 10'd0,   1'b1, 32'h0);
        tbl[14] = mkv(OP_PUSH, 2'd1, 32'hBEEF, 4'b0001, 10'd256, 1'b0, 32'h0);
        tbl[15] = mkv(OP_PUSH, 2'd1, 32'hCAFE, 4'b0010, 10'd256, 1'b0, 32'h0);
        tbl[16] = mkv(OP_PUSH, 2'd1, 32'h7,    4'b0100, 10'd256, 1'b0, 32'h0);
        tbl[17] = mkv(OP_PUSH, 2'd1, 32'h8,    4'b1000, 10'd256, 1'b0, 32'h0);
        tbl[18] = mkv(OP_PUSH, 2'd1, 32'h9,    4'b0001, 10'd257, 1'b0, 32'h0);
        tbl[19] = mkv(OP_POP,  2'd3, 32'h0,    4'b0001, 10'd768, 1'b0, 32'h3);
        tbl[20] = mkv(OP_POP,  2'd1, 32'h0,    4'b0001, 10'd257, 1'b0, 32'h9);
        tbl[21] = mkv(OP_PUSH, 2'd1, 32'hA,    4'b0001, 10'd257, 1'b0, 32'h0);

        rst = 1'b1; cmd_vld = 1'b0; cmd_opcode = OP_NOP; cmd_engid = 2'd0; cmd_data = 32'd0;
        repeat (3) @(negedge clk);
        chk("rdy_in_reset", 64'(cmd_rdy), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_state", 64'({cmd_rdy, rsp_vld, rsp_err, rsp_data, bank_en, bank_wen, eng_empty, eng_full}),
            64'({1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0, 4'hF, 4'h0}));

        // PUSH/POP round trip with exact T+2 response latency
        send("push_a5", mkv(OP_PUSH, 2'd0, 32'hA5, 4'b0001, 10'd0, 1'b0, 32'h0));
        cmd_vld = 1'b0;
        chk("lat_t1", 64'(rsp_vld), 64'd0);
        @(negedge clk);
        chk("lat_t2", 64'(rsp_vld), 64'd1);
        send("pop_a5", mkv(OP_POP, 2'd0, 32'h0, 4'b0001, 10'd0, 1'b0, 32'hA5));
        idle(3);
        chk("empty_after_pop", 64'(eng_empty), 64'hF);

        for (int i = 0; i < 22; i++) send($sformatf("vec%0d", i), tbl[i]);
        chk("empty_after_tbl", 64'(eng_empty), 64'hD);
        idle(3);

        // INV on an engine holding 5 entries
        send("inv_e1", mkv(OP_INV, 2'd1, 32'h0, 4'b0000, 10'd0, 1'b0, 32'h0));
        cmd_vld = 1'b0;
        chk("inv_empty", 64'(eng_empty), 64'hF);
`ifdef STK_CTX_CTRL_SCRUB_EN
        begin
            int sc = 0;
            while (cmd_rdy !== 1'b1 && sc < 400) begin
                chk($sformatf("scrub%0d", sc), 64'({bank_en, bank_wen, bank_addr, bank_wdata}),
                    64'({4'hF, 1'b1, 10'(256 + sc), 32'd0}));
                sc++;
                @(negedge clk);
            end
            chk("scrub_len", 64'(sc), 64'd256);
            chk("inv_rsp_after_scrub", 64'(rsp_vld), 64'd1);
        end
`endif
        idle(3);
        send("pop_after_inv", mkv(OP_POP, 2'd1, 32'h0, 4'b0000, 10'd0, 1'b1, 32'h0));
        idle(3);

        // Fill engine 2 back to back, then overflow
        for (int i = 0; i < 1024; i++)
            send($sformatf("fill%0d", i), mkv(OP_PUSH, 2'd2, 32'h100 + 32'(i), 4'(1 << (i % 4)),
                                              10'(512 + i / 4), 1'b0, 32'h0));
        chk("full_e2", 64'(eng_full), 64'h4);
        send("push_overflow", mkv(OP_PUSH, 2'd2, 32'hDEAD, 4'b0000, 10'd0, 1'b1, 32'h0));
        chk("full_e2_held", 64'(eng_full), 64'h4);
        send("pop_top_e2", mkv(OP_POP, 2'd2, 32'h0, 4'b1000, 10'd767, 1'b0, 32'h4FF));
        chk("full_e2_clear", 64'(eng_full), 64'h0);
        idle(4);

        // Reset one cycle after a POP is accepted
        send("push_pre_rst", mkv(OP_PUSH, 2'd3, 32'h55, 4'b0001, 10'd768, 1'b0, 32'h0));
        idle(4);
        send("pop_pre_rst", mkv(OP_POP, 2'd3, 32'h0, 4'b0001, 10'd768, 1'b0, 32'h55));
        cmd_vld = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("rst_rsp_t2", 64'({rsp_vld, bank_en, cmd_rdy}), 64'd0);
        @(negedge clk);
        chk("rst_rsp_t3", 64'(rsp_vld), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst", 64'({cmd_rdy, rsp_vld, eng_empty, eng_full}), 64'({1'b1, 1'b0, 4'hF, 4'h0}));
        idle(3);

        begin
            int dc = 0;
            while (exp_q.size() != 0 && dc < 300) begin
                @(negedge clk);
                dc++;
            end
        end
        chk("rsp_drain", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end
endmodule
